s2p_align_ctrl: RTL and testbench

- Byte-alignment and lock controller for the serial-to-parallel receive path of the byte-striping link.
- Watches the MSB-first serial bitstream on the fast clock and hunts for the COM symbol.
- Declares lock after a run of COM symbols on a consistent byte boundary, then emits framed bytes with strobe/valid.
- Drops lock when COMs stop arriving or when software requests a realign. Sits between the serial lane input and the lane un-striping logic.

---
 rtl/s2p_align_ctrl_pkg.sv | 21 ++
 rtl/s2p_com_detect.sv | 24 ++
 rtl/s2p_align_ctrl.sv | 146 ++++++++++++++
 tb/tb_s2p_align_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/s2p_align_ctrl_pkg.sv
// Shared constants for the serial-to-parallel byte aligner: FSM encodings,
// default COM symbol, counter widths and the framed-byte output record.
package s2p_align_ctrl_pkg;

  localparam logic [1:0] ST_HUNT   = 2'b00;
  localparam logic [1:0] ST_CHECK  = 2'b01;
  localparam logic [1:0] ST_LOCKED = 2'b10;

  localparam logic [7:0] COM_SYM_DEF = 8'hBC;

  localparam int BIT_CNT_W = 3;
  localparam int COM_CNT_W = 4;
  localparam int GAP_CNT_W = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       strobe;
  } byte_out_t;

endpackage

// File: rtl/s2p_com_detect.sv
// Serial shift register plus COM compare; cand includes the bit arriving this cycle.
module s2p_com_detect
  import s2p_align_ctrl_pkg::*;
#(
  parameter logic [7:0] COM_SYM = COM_SYM_DEF
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] cand,
  output logic       com_hit
);

  logic [7:0] shift_reg;

  assign cand    = {shift_reg[6:0], data_in};
  assign com_hit = (cand == COM_SYM);

  always_ff @(posedge clk_8f) begin
    if (reset) shift_reg <= 8'h00;
    else       shift_reg <= cand;
  end

endmodule

// File: rtl/s2p_align_ctrl.sv
// Byte-alignment / lock controller: HUNT -> CHECK -> LOCKED on consecutive COMs.
// Optional LOCKED->HUNT counter output enabled by S2P_ALIGN_RELOCK_CNT_EN.
module s2p_align_ctrl
  import s2p_align_ctrl_pkg::*;
#(
  parameter logic [7:0] COM_SYM   = COM_SYM_DEF,
  parameter int         COM_COUNT = 4,
  parameter int         MAX_GAP   = 16
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_in,
  input  logic       realign,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       locked,
  output logic [1:0] state
`ifdef S2P_ALIGN_RELOCK_CNT_EN
  ,
  output logic [7:0] relock_cnt
`endif
);

  localparam logic [COM_CNT_W-1:0] COM_TGT = COM_CNT_W'(COM_COUNT);
  localparam logic [GAP_CNT_W-1:0] GAP_MAX = GAP_CNT_W'(MAX_GAP);

  logic [7:0]           cand;
  logic                 com_hit;
  logic [1:0]           state_nxt;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_nxt;
  logic [COM_CNT_W-1:0] com_cnt, com_nxt;
  logic [GAP_CNT_W-1:0] gap_cnt, gap_nxt;
  byte_out_t            out_q, out_nxt;
  logic                 boundary;

  s2p_com_detect #(.COM_SYM(COM_SYM)) u_det (
    .clk_8f (clk_8f),
    .reset  (reset),
    .data_in(data_in),
    .cand   (cand),
    .com_hit(com_hit)
  );

  assign boundary = (bit_cnt == 3'd7);

  always_comb begin
    state_nxt      = state;
    bit_nxt        = bit_cnt;
    com_nxt        = com_cnt;
    gap_nxt        = gap_cnt;
    out_nxt.data   = out_q.data;
    out_nxt.valid  = 1'b0;
    out_nxt.strobe = 1'b0;
    if (realign) begin
      state_nxt = ST_HUNT;
      bit_nxt   = '0;
      com_nxt   = '0;
      gap_nxt   = '0;
    end else begin
      case (state)
        ST_HUNT: begin
          if (com_hit) begin
            bit_nxt = '0;
            com_nxt = 4'd1;
            gap_nxt = '0;
            state_nxt = (COM_TGT == 4'd1) ? ST_LOCKED : ST_CHECK;
          end
        end
        ST_CHECK: begin
          bit_nxt = bit_cnt + 3'd1;
          if (boundary) begin
            if (com_hit) begin
              com_nxt = com_cnt + 4'd1;
              if (com_nxt == COM_TGT) begin
                state_nxt = ST_LOCKED;
                gap_nxt   = '0;
              end
            end else begin
              state_nxt = ST_HUNT;
              bit_nxt   = '0;
              com_nxt   = '0;
            end
          end
        end
        ST_LOCKED: begin
          bit_nxt = bit_cnt + 3'd1;
          if (boundary) begin
            out_nxt.data   = cand;
            out_nxt.strobe = 1'b1;
            out_nxt.valid  = !com_hit;
            if (com_hit) begin
              gap_nxt = '0;
            end else if (gap_cnt >= GAP_MAX) begin
              // Byte still goes out; lock is dropped alongside it.
              state_nxt = ST_HUNT;
              bit_nxt   = '0;
              com_nxt   = '0;
              gap_nxt   = '0;
            end else begin
              gap_nxt = gap_cnt + 8'd1;
            end
          end
        end
        default: begin
          state_nxt = ST_HUNT;
          bit_nxt   = '0;
          com_nxt   = '0;
          gap_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state   <= ST_HUNT;
      bit_cnt <= '0;
      com_cnt <= '0;
      gap_cnt <= '0;
      out_q   <= '0;
      locked  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_nxt;
      com_cnt <= com_nxt;
      gap_cnt <= gap_nxt;
      out_q   <= out_nxt;
      locked  <= (state_nxt == ST_LOCKED);
    end
  end

`ifdef S2P_ALIGN_RELOCK_CNT_EN
  always_ff @(posedge clk_8f) begin
    if (reset)
      relock_cnt <= 8'h00;
    else if (state == ST_LOCKED && state_nxt == ST_HUNT && relock_cnt != 8'hFF)
      relock_cnt <= relock_cnt + 8'd1;
  end
`endif

  assign data_out    = out_q.data;
  assign valid_out   = out_q.valid;
  assign byte_strobe = out_q.strobe;

endmodule

// File: tb/tb_s2p_align_ctrl.sv
// Directed bench for s2p_align_ctrl (COM_COUNT=4, MAX_GAP=16); define
// S2P_ALIGN_RELOCK_CNT_EN to also check relock_cnt.
module tb_s2p_align_ctrl;

  logic       clk_8f = 1'b0;
  logic       reset, data_in, realign;
  logic [7:0] data_out;
  logic       valid_out, byte_strobe, locked;
  logic [1:0] state;
`ifdef S2P_ALIGN_RELOCK_CNT_EN
  logic [7:0] relock_cnt;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int stray = 0;

  always #5 clk_8f = ~clk_8f;

  s2p_align_ctrl #(.COM_SYM(8'hBC), .COM_COUNT(4), .MAX_GAP(16)) dut (
    .clk_8f     (clk_8f),
    .reset      (reset),
    .data_in    (data_in),
    .realign    (realign),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .byte_strobe(byte_strobe),
    .locked     (locked),
    .state      (state)
`ifdef S2P_ALIGN_RELOCK_CNT_EN
    ,
    .relock_cnt (relock_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one bit, let the edge sample it, look at outputs 1 time unit later.
  task automatic tick(input logic b);
    data_in = b;
    @(posedge clk_8f);
    #1;
  endtask

  // MSB first; any strobe before the last bit of a byte is counted as stray.
  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      tick(b[i]);
      if (i != 0 && byte_strobe !== 1'b0) stray++;
    end
  endtask

  initial begin
    reset = 1'b1; realign = 1'b0; data_in = 1'b0;
    tick(1'b1);
    tick(1'b1);
    chk("rst_state", state, 2'b00);
    chk("rst_locked", locked, 1'b0);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_strobe", byte_strobe, 1'b0);
`ifdef S2P_ALIGN_RELOCK_CNT_EN
    chk("rst_relock", relock_cnt, 8'h00);
`endif
    reset = 1'b0;

    // All-zero stream never locks
    for (int i = 0; i < 100; i++) begin
      tick(1'b0);
      if (byte_strobe !== 1'b0) stray++;
    end
    chk("zero_state", state, 2'b00);
    chk("zero_locked", locked, 1'b0);
    chk("zero_dout", data_out, 8'h00);
    chk("zero_strobes", stray, 0);

    // Preamble 101 then four COMs
    tick(1'b1); tick(1'b0); tick(1'b1);
    chk("pre_state", state, 2'b00);
    send_byte(8'hBC);
    chk("com1_state", state, 2'b01);
    chk("com1_strobe", byte_strobe, 1'b0);
    send_byte(8'hBC);
    chk("com2_state", state, 2'b01);
    send_byte(8'hBC);
    chk("com3_state", state, 2'b01);
    chk("com3_locked", locked, 1'b0);
    send_byte(8'hBC);
    chk("com4_state", state, 2'b10);
    chk("com4_locked", locked, 1'b1);
    chk("com4_strobe", byte_strobe, 1'b0);

    // Framed bytes A5, BC, 3C
    send_byte(8'hA5);
    chk("a5_strobe", byte_strobe, 1'b1);
    chk("a5_valid", valid_out, 1'b1);
    chk("a5_dout", data_out, 8'hA5);
    send_byte(8'hBC);
    chk("bc_strobe", byte_strobe, 1'b1);
    chk("bc_valid", valid_out, 1'b0);
    chk("bc_dout", data_out, 8'hBC);
    send_byte(8'h3C);
    chk("3c_strobe", byte_strobe, 1'b1);
    chk("3c_valid", valid_out, 1'b1);
    chk("3c_dout", data_out, 8'h3C);
    chk("lock_stray", stray, 0);

    // COM clears gap, then 17 non-COM bytes: 17th is output and drops lock
    send_byte(8'hBC);
    for (int k = 1; k <= 17; k++) begin
      send_byte(8'(k));
      if (k == 16) begin
        chk("gap16_state", state, 2'b10);
        chk("gap16_valid", valid_out, 1'b1);
      end
    end
    chk("gap17_strobe", byte_strobe, 1'b1);
    chk("gap17_valid", valid_out, 1'b1);
    chk("gap17_dout", data_out, 8'h11);
    chk("gap17_state", state, 2'b00);
    chk("gap17_locked", locked, 1'b0);
`ifdef S2P_ALIGN_RELOCK_CNT_EN
    chk("gap_relock", relock_cnt, 8'h01);
`endif
    tick(1'b0);
    chk("gap_post_strobe", byte_strobe, 1'b0);

    // Two COMs then 55 aborts CHECK; relock on a phase 3 bits later
    send_byte(8'h00);
    send_byte(8'hBC);
    chk("chk1_state", state, 2'b01);
    send_byte(8'hBC);
    chk("chk2_state", state, 2'b01);
    send_byte(8'h55);
    chk("abort_state", state, 2'b00);
    chk("abort_comcnt", dut.com_cnt, 4'd0);
    tick(1'b0); tick(1'b0); tick(1'b0);
    for (int k = 1; k <= 4; k++) begin
      send_byte(8'hBC);
      chk("phase_state", state, (k == 4) ? 2'b10 : 2'b01);
    end
    send_byte(8'hA5);
    chk("phase_strobe", byte_strobe, 1'b1);
    chk("phase_dout", data_out, 8'hA5);

    // Realign on the last bit of a COM
    for (int i = 7; i >= 1; i--) tick(1'(8'hBC >> i));
    realign = 1'b1;
    tick(1'b0);
    realign = 1'b0;
    chk("ra_strobe", byte_strobe, 1'b0);
    chk("ra_valid", valid_out, 1'b0);
    chk("ra_state", state, 2'b00);
    chk("ra_locked", locked, 1'b0);
    chk("ra_dout", data_out, 8'hA5);
`ifdef S2P_ALIGN_RELOCK_CNT_EN
    chk("ra_relock", relock_cnt, 8'h02);
`endif
    for (int k = 1; k <= 4; k++) begin
      send_byte(8'hBC);
      chk("rl_state", state, (k == 4) ? 2'b10 : 2'b01);
    end
    chk("rl_locked", locked, 1'b1);
    send_byte(8'h3C);
    chk("rl_strobe", byte_strobe, 1'b1);
    chk("rl_dout", data_out, 8'h3C);
`ifdef S2P_ALIGN_RELOCK_CNT_EN
    chk("rl_relock", relock_cnt, 8'h02);
`endif
    chk("final_stray", stray, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
